// File: rtl/obi_mem_arbiter.sv
// rtl/obi_mem_arbiter.sv - two-master OBI arbiter onto one memory port with in-order response routing
module obi_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  mst_req_i,
  output logic [1:0]  mst_gnt_o,
  output logic [1:0]  mst_rvalid_o,
  input  logic [63:0] mst_addr_i,
  input  logic [1:0]  mst_we_i,
  input  logic [7:0]  mst_be_i,
  input  logic [63:0] mst_wdata_i,
  output logic [31:0] mst_rdata_o,
  output logic        mst_err_o,
  output logic        slv_req_o,
  input  logic        slv_gnt_i,
  input  logic        slv_rvalid_i,
  output logic [31:0] slv_addr_o,
  output logic        slv_we_o,
  output logic [3:0]  slv_be_o,
  output logic [31:0] slv_wdata_o,
  input  logic [31:0] slv_rdata_i,
  input  logic        slv_err_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_ids [MAX_OUTSTANDING];
  logic          r_lock;
  logic          r_lock_sel;
  logic          r_rr;

  logic          w_sel;
  logic          w_slv_req;
  logic          w_hs;
  logic          w_pop;
  logic          w_head;

  // A locked request must be presented unchanged until the memory grants it.
  always_comb begin
    w_sel = r_rr;
    if (r_lock) begin
      w_sel = r_lock_sel;
    end else if (mst_req_i == 2'b01) begin
      w_sel = 1'b0;
    end else if (mst_req_i == 2'b10) begin
      w_sel = 1'b1;
    end
  end

  assign w_slv_req = mst_req_i[w_sel] && (r_count < MAX_CNT);
  assign w_hs      = w_slv_req && slv_gnt_i;
  assign w_pop     = slv_rvalid_i && (r_count != '0);
  assign w_head    = r_ids[r_rptr];

  assign slv_req_o   = w_slv_req;
  assign slv_addr_o  = w_slv_req ? (w_sel ? mst_addr_i[63:32]  : mst_addr_i[31:0])  : 32'h0;
  assign slv_we_o    = w_slv_req ? (w_sel ? mst_we_i[1]        : mst_we_i[0])        : 1'b0;
  assign slv_be_o    = w_slv_req ? (w_sel ? mst_be_i[7:4]      : mst_be_i[3:0])      : 4'h0;
  assign slv_wdata_o = w_slv_req ? (w_sel ? mst_wdata_i[63:32] : mst_wdata_i[31:0]) : 32'h0;

  assign mst_gnt_o    = w_hs  ? (w_sel  ? 2'b10 : 2'b01) : 2'b00;
  assign mst_rvalid_o = w_pop ? (w_head ? 2'b10 : 2'b01) : 2'b00;
  assign mst_rdata_o  = slv_rdata_i;
  assign mst_err_o    = slv_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_lock     <= 1'b0;
      r_lock_sel <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
        r_rr   <= ~w_sel;
        r_lock <= 1'b0;
      end else if (w_slv_req) begin
        r_lock     <= 1'b1;
        r_lock_sel <= w_sel;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      end
      if (w_hs && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_hs && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // ID storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_ids[r_wptr] <= w_sel;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb/tb_obi_mem_arbiter.sv - directed bench with queue-based reference model for obi_mem_arbiter
module tb_obi_mem_arbiter;

  localparam int MAXO = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mst_req;
  logic [1:0]  mst_gnt;
  logic [1:0]  mst_rvalid;
  logic [63:0] mst_addr;
  logic [1:0]  mst_we;
  logic [7:0]  mst_be;
  logic [63:0] mst_wdata;
  logic [31:0] mst_rdata;
  logic        mst_err;
  logic        slv_req;
  logic        slv_gnt;
  logic        slv_rvalid;
  logic [31:0] slv_addr;
  logic        slv_we;
  logic [3:0]  slv_be;
  logic [31:0] slv_wdata;
  logic [31:0] slv_rdata;
  logic        slv_err;

  int n_checks = 0;
  int n_fail   = 0;

  obi_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mst_req_i    (mst_req),
    .mst_gnt_o    (mst_gnt),
    .mst_rvalid_o (mst_rvalid),
    .mst_addr_i   (mst_addr),
    .mst_we_i     (mst_we),
    .mst_be_i     (mst_be),
    .mst_wdata_i  (mst_wdata),
    .mst_rdata_o  (mst_rdata),
    .mst_err_o    (mst_err),
    .slv_req_o    (slv_req),
    .slv_gnt_i    (slv_gnt),
    .slv_rvalid_i (slv_rvalid),
    .slv_addr_o   (slv_addr),
    .slv_we_o     (slv_we),
    .slv_be_o     (slv_be),
    .slv_wdata_o  (slv_wdata),
    .slv_rdata_i  (slv_rdata),
    .slv_err_i    (slv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: outstanding IDs in order, lock/preferred master per the arbitration rules.
  int q[$];
  bit m_lock;
  int m_lsel;
  int m_rr;

  always @(negedge clk) begin
    int  s;
    bit  e_req, e_hs, e_pop;
    logic [1:0] e_rv;
    if (!rst_n) begin
      q.delete();
      m_lock = 0;
      m_rr   = 0;
    end
    if (m_lock)                s = m_lsel;
    else if (mst_req == 2'b01) s = 0;
    else if (mst_req == 2'b10) s = 1;
    else                       s = m_rr;
    e_req = mst_req[s] && (q.size() < MAXO);
    e_hs  = e_req && slv_gnt;
    e_pop = slv_rvalid && (q.size() > 0);
    e_rv  = e_pop ? ((q[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("slv_req",   64'(slv_req),   64'(e_req));
    chk("slv_addr",  64'(slv_addr),  e_req ? 64'(mst_addr[s*32 +: 32])  : 64'h0);
    chk("slv_we",    64'(slv_we),    e_req ? 64'(mst_we[s])             : 64'h0);
    chk("slv_be",    64'(slv_be),    e_req ? 64'(mst_be[s*4 +: 4])      : 64'h0);
    chk("slv_wdata", 64'(slv_wdata), e_req ? 64'(mst_wdata[s*32 +: 32]) : 64'h0);
    chk("mst_gnt",   64'(mst_gnt),   e_hs ? ((s == 1) ? 64'h2 : 64'h1) : 64'h0);
    chk("mst_rvalid", 64'(mst_rvalid), 64'(e_rv));
    chk("mst_rdata", 64'(mst_rdata), 64'(slv_rdata));
    chk("mst_err",   64'(mst_err),   64'(slv_err));
    if (rst_n) begin
      if (e_pop) void'(q.pop_front());
      if (e_hs) begin
        q.push_back(s);
        m_rr   = 1 - s;
        m_lock = 0;
      end else if (e_req) begin
        m_lock = 1;
        m_lsel = s;
      end
    end
  end

  int step = 0;

  task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv);
    @(posedge clk);
    #1;
    step++;
    mst_req    = req;
    slv_gnt    = gnt;
    slv_rvalid = rv;
    slv_rdata  = 32'hA500_0000 + 32'(step);
    slv_err    = step[0];
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    mst_req    = 2'b00;
    slv_gnt    = 1'b0;
    slv_rvalid = 1'b1;
    @(negedge clk);
    chk("rst_rvalid", 64'(mst_rvalid), 64'h0);
    chk("rst_req",    64'(slv_req),    64'h0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    slv_rvalid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mst_req    = 2'b00;
    slv_gnt    = 1'b0;
    slv_rvalid = 1'b0;
    slv_rdata  = 32'h0;
    slv_err    = 1'b0;
    mst_addr   = {32'h2000_0004, 32'h1000_0000};
    mst_we     = 2'b01;
    mst_be     = 8'h3F;
    mst_wdata  = {32'hBEEF_1111, 32'hDEAD_0000};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 64'(mst_gnt), 64'h0);
    rst_n = 1'b1;

    // Alternating grants with one-cycle-later responses
    cyc(2'b11, 1'b1, 1'b0); chk("rr_g0", 64'(mst_gnt), 64'h1);
    cyc(2'b11, 1'b1, 1'b1); chk("rr_g1", 64'(mst_gnt), 64'h2); chk("rr_r0", 64'(mst_rvalid), 64'h1);
    cyc(2'b11, 1'b1, 1'b1); chk("rr_g2", 64'(mst_gnt), 64'h1); chk("rr_r1", 64'(mst_rvalid), 64'h2);
    cyc(2'b11, 1'b1, 1'b1); chk("rr_g3", 64'(mst_gnt), 64'h2); chk("rr_r2", 64'(mst_rvalid), 64'h1);
    cyc(2'b00, 1'b0, 1'b1); chk("rr_r3", 64'(mst_rvalid), 64'h2);

    // Lock holds master 1 while memory stalls
    mst_addr[63:32] = 32'h0000_0100;
    cyc(2'b10, 1'b0, 1'b0); chk("lk_a0", 64'(slv_addr), 64'h100); chk("lk_g0", 64'(mst_gnt), 64'h0);
    cyc(2'b11, 1'b0, 1'b0); chk("lk_a1", 64'(slv_addr), 64'h100);
    cyc(2'b11, 1'b0, 1'b0); chk("lk_a2", 64'(slv_addr), 64'h100);
    cyc(2'b11, 1'b1, 1'b0); chk("lk_g1", 64'(mst_gnt), 64'h2);
    cyc(2'b11, 1'b1, 1'b0); chk("lk_g2", 64'(mst_gnt), 64'h1); chk("lk_a3", 64'(slv_addr), 64'h1000_0000);
    cyc(2'b00, 1'b0, 1'b1); chk("lk_r0", 64'(mst_rvalid), 64'h2);
    cyc(2'b00, 1'b0, 1'b1); chk("lk_r1", 64'(mst_rvalid), 64'h1);

    // Outstanding limit, blocked even in the popping cycle
    mst_addr[31:0] = 32'h0000_0040;
    mst_be         = 8'h5A;
    cyc(2'b01, 1'b1, 1'b0); chk("mx_g0", 64'(mst_gnt), 64'h1);
    cyc(2'b01, 1'b1, 1'b0); chk("mx_g1", 64'(mst_gnt), 64'h1);
    cyc(2'b01, 1'b1, 1'b0); chk("mx_blk", 64'(slv_req), 64'h0); chk("mx_g2", 64'(mst_gnt), 64'h0);
    cyc(2'b01, 1'b1, 1'b1); chk("mx_blkpop", 64'(slv_req), 64'h0); chk("mx_r0", 64'(mst_rvalid), 64'h1);
    cyc(2'b01, 1'b1, 1'b0); chk("mx_unblk", 64'(slv_req), 64'h1); chk("mx_g3", 64'(mst_gnt), 64'h1);
    cyc(2'b00, 1'b0, 1'b1); chk("mx_r1", 64'(mst_rvalid), 64'h1);

    // Simultaneous push and pop at count 1
    cyc(2'b10, 1'b1, 1'b1); chk("pp_g", 64'(mst_gnt), 64'h2); chk("pp_r", 64'(mst_rvalid), 64'h1);
    cyc(2'b00, 1'b0, 1'b1); chk("pp_r2", 64'(mst_rvalid), 64'h2);

    // Stray response with nothing outstanding
    cyc(2'b00, 1'b0, 1'b1); chk("st_r", 64'(mst_rvalid), 64'h0);
    cyc(2'b11, 1'b1, 1'b0); chk("st_g", 64'(mst_gnt), 64'h1);

    // Reset with two outstanding
    cyc(2'b11, 1'b1, 1'b0); chk("rs_g0", 64'(mst_gnt), 64'h2);
    cyc(2'b11, 1'b0, 1'b0); chk("rs_full", 64'(slv_req), 64'h0);
    do_reset();
    cyc(2'b00, 1'b0, 1'b1); chk("rs_stray", 64'(mst_rvalid), 64'h0);
    cyc(2'b11, 1'b1, 1'b0); chk("rs_g1", 64'(mst_gnt), 64'h1);

    // Reset while locked on master 1
    cyc(2'b10, 1'b0, 1'b0); chk("rl_g0", 64'(mst_gnt), 64'h0);
    do_reset();
    cyc(2'b11, 1'b1, 1'b0); chk("rl_g1", 64'(mst_gnt), 64'h1);
    cyc(2'b11, 1'b1, 1'b1);
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
